fp_add_pipe: RTL

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

---
 rtl/fp_add_pipe.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor.
// Stage 1 compares and aligns, stage 2 adds or subtracts, stage 3
// normalizes, then saturates or flushes and packs the result.
// Rounding is by truncation. A single global advance enable stalls the
// whole pipeline whenever the output is holding an unaccepted result.
// Optional build macro FP_ADD_PIPE_SPECIAL_EN: adds handling of zero,
// Inf and NaN operands. When it is undefined, every operand is treated
// as a normal number.
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         ovf,
  output logic         unf
);

  localparam int EW   = EXP_W + 2;
  localparam int SH_W = $clog2(MAN_W + 2);
  localparam logic [EXP_W-1:0]        MAN_LIM = EXP_W'(MAN_W);
  localparam logic signed [EW-1:0]    EMAX    = $signed({2'b00, {EXP_W{1'b1}}});
  localparam logic signed [EW-1:0]    EZERO   = '0;

  // Left-shift distance that brings the leading one up to bit MAN_W.
  function automatic logic [SH_W-1:0] lead_shift(input logic [MAN_W:0] m);
    lead_shift = '0;
    for (int i = 0; i <= MAN_W; i++)
      if (m[i]) lead_shift = SH_W'(MAN_W - i);
  endfunction

  // Saturate to Inf, flush to zero, or pack normally; returns {ovf, unf, word}.
  function automatic logic [W+1:0] pack(input logic s, input logic signed [EW-1:0] e,
                                        input logic [MAN_W-1:0] f, input logic z);
    if (z)               pack = '0;
    else if (e >= EMAX)  pack = {2'b10, s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (e <= EZERO) pack = {2'b01, s, {(EXP_W+MAN_W){1'b0}}};
    else                 pack = {2'b00, s, e[EXP_W-1:0], f};
  endfunction

  logic en;
  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  logic             sa, sb, a_big;
  logic [EXP_W-1:0] ebig, esml, ediff;
  logic [MAN_W:0]   mbig, msml, mal;

  // Operand compare: pick the larger magnitude and align the smaller one.
  always_comb begin
    sa    = a[W-1];
    sb    = b[W-1] ^ op;
    a_big = (a[W-2:0] >= b[W-2:0]);
    ebig  = a_big ? a[W-2:MAN_W] : b[W-2:MAN_W];
    esml  = a_big ? b[W-2:MAN_W] : a[W-2:MAN_W];
    mbig  = a_big ? {1'b1, a[MAN_W-1:0]} : {1'b1, b[MAN_W-1:0]};
    msml  = a_big ? {1'b1, b[MAN_W-1:0]} : {1'b1, a[MAN_W-1:0]};
    ediff = ebig - esml;
    mal   = (ediff > MAN_LIM) ? '0 : (msml >> ediff);
  end

  // ---- stage 1: compare/align ----
  logic             vld_p1, sign_p1, sub_p1;
  logic [EXP_W-1:0] exp_p1;
  logic [MAN_W:0]   mbig_p1, msml_p1;

  // Capture the aligned operand pair on each accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      sign_p1 <= 1'b0;
      sub_p1  <= 1'b0;
      exp_p1  <= '0;
      mbig_p1 <= '0;
      msml_p1 <= '0;
    end else if (en) begin
      vld_p1  <= in_valid;
      sign_p1 <= a_big ? sa : sb;
      sub_p1  <= sa ^ sb;
      exp_p1  <= ebig;
      mbig_p1 <= mbig;
      msml_p1 <= mal;
    end
  end

  // ---- stage 2: add/subtract ----
  logic             vld_p2, sign_p2;
  logic [EXP_W-1:0] exp_p2;
  logic [MAN_W+1:0] sum_p2;

  // Magnitude add or subtract; the larger operand is always the minuend.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      sign_p2 <= 1'b0;
      exp_p2  <= '0;
      sum_p2  <= '0;
    end else if (en) begin
      vld_p2  <= vld_p1;
      sign_p2 <= sign_p1;
      exp_p2  <= exp_p1;
      sum_p2  <= sub_p1 ? ({1'b0, mbig_p1} - {1'b0, msml_p1})
                        : ({1'b0, mbig_p1} + {1'b0, msml_p1});
    end
  end

`ifdef FP_ADD_PIPE_SPECIAL_EN
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic         a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic         spec_s0, spec_p1, spec_p2;
  logic [W-1:0] spec_c_s0, spec_c_p1, spec_c_p2;

  // Classify operands and pick the special-case result, if any.
  always_comb begin
    a_zero    = (a[W-2:MAN_W] == '0);
    b_zero    = (b[W-2:MAN_W] == '0);
    a_nan     = (&a[W-2:MAN_W]) &  (|a[MAN_W-1:0]);
    b_nan     = (&b[W-2:MAN_W]) &  (|b[MAN_W-1:0]);
    a_inf     = (&a[W-2:MAN_W]) & ~(|a[MAN_W-1:0]);
    b_inf     = (&b[W-2:MAN_W]) & ~(|b[MAN_W-1:0]);
    spec_s0   = 1'b1;
    spec_c_s0 = '0;
    if (a_nan | b_nan | (a_inf & b_inf & (sa != sb))) spec_c_s0 = QNAN;
    else if (a_inf)  spec_c_s0 = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (b_inf)  spec_c_s0 = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (a_zero) spec_c_s0 = b_zero ? {sb, {(W-1){1'b0}}} : {sb, b[W-2:0]};
    else if (b_zero) spec_c_s0 = a;
    else             spec_s0   = 1'b0;
  end

  // Carry the special-case override alongside the arithmetic stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spec_p1   <= 1'b0;
      spec_p2   <= 1'b0;
      spec_c_p1 <= '0;
      spec_c_p2 <= '0;
    end else if (en) begin
      spec_p1   <= spec_s0;
      spec_p2   <= spec_p1;
      spec_c_p1 <= spec_c_s0;
      spec_c_p2 <= spec_c_p1;
    end
  end
`endif

  logic [SH_W-1:0]       sh;
  logic [MAN_W:0]        shifted;
  logic [MAN_W-1:0]      nfrac;
  logic signed [EW-1:0]  nexp;
  logic [W+1:0]          res;

  // Normalize the sum and pack it with saturation/flush.
  always_comb begin
    sh      = lead_shift(sum_p2[MAN_W:0]);
    shifted = sum_p2[MAN_W:0] << sh;
    if (sum_p2[MAN_W+1]) begin
      nfrac = sum_p2[MAN_W:1];
      nexp  = $signed({2'b00, exp_p2} + EW'(1));
    end else begin
      nfrac = shifted[MAN_W-1:0];
      nexp  = $signed({2'b00, exp_p2} - EW'(sh));
    end
    res = pack(sign_p2, nexp, nfrac, (sum_p2 == '0));
`ifdef FP_ADD_PIPE_SPECIAL_EN
    if (spec_p2) res = {2'b00, spec_c_p2};
`endif
  end

  // ---- stage 3: normalize/pack ----
  // Output register; holds while downstream is not accepting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      c         <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else if (en) begin
      out_valid <= vld_p2;
      c         <= res[W-1:0];
      ovf       <= res[W+1];
      unf       <= res[W];
    end
  end

endmodule
